axi_slv_mem_sched: RTL and testbench

// Scheduler for a single-port SRAM behind the AXI3 slave: accepts write (AW/W) and read (AR) bursts, serialises them onto one memory port,

---
 rtl/axi_slv_pkg.sv | 17 +
 rtl/axi_slv_rr_arb.sv | 27 ++
 rtl/axi_slv_mem_sched.sv | 192 +++++++++++++++++++
 tb/tb_axi_slv_mem_sched.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types and encodings for the AXI3 slave memory scheduler.
package axi_slv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } sched_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/axi_slv_rr_arb.sv
// Two-requester round-robin arbiter; a tie goes to the side not granted last.
module axi_slv_rr_arb (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic grant_wr,
  output logic grant_rd
);

  logic last_wr_q;

  assign grant_wr = en && req_wr && (!req_rd || !last_wr_q);
  assign grant_rd = en && req_rd && (!req_wr || last_wr_q);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      last_wr_q <= 1'b0;
    end else if (grant_wr) begin
      last_wr_q <= 1'b1;
    end else if (grant_rd) begin
      last_wr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_slv_mem_sched.sv
// Serialises AXI3 write and read bursts onto a single-port SRAM, one burst at a time,
// with burst-granular round-robin arbitration and registered B/R responses.
module axi_slv_mem_sched
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024,
  localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH),
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AW_ADDR,
  input  logic [ID_WIDTH-1:0]   AW_ID,
  input  logic [3:0]            AW_LEN,
  input  logic [1:0]            AW_BURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AR_ADDR,
  input  logic [ID_WIDTH-1:0]   AR_ID,
  input  logic [3:0]            AR_LEN,
  input  logic [1:0]            AR_BURST,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  input  logic [DATA_WIDTH-1:0] W_DATA,
  input  logic [STRB_W-1:0]     W_STRB,
  input  logic                  W_LAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   B_ID,
  output logic [1:0]            B_RESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [ID_WIDTH-1:0]   R_ID,
  output logic [1:0]            R_RESP,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic                  R_LAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_W-1:0]     mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [MEM_AW:0] DepthLim = (MEM_AW+1)'(MEM_DEPTH);

  sched_state_e          state_q;
  logic [MEM_AW-1:0]     addr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [3:0]            len_q;
  logic [3:0]            cnt_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic                  werr_q;
  logic                  rd_first_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                grant_wr, grant_rd;
  logic [MEM_AW-1:0]   sel_word;
  logic [3:0]          sel_len;
  logic [1:0]          sel_burst;
  logic [MEM_AW:0]     sel_end;
  logic                sel_err;
  logic                wr_beat;
  logic [MEM_AW-1:0]   addr_next;
  logic                unused_bits;

  axi_slv_rr_arb u_arb (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .en       (state_q == IDLE),
    .req_wr   (AWVALID),
    .req_rd   (AR_VALID),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  assign AWREADY  = grant_wr;
  assign AR_READY = grant_rd;

  assign sel_word  = grant_wr ? AW_ADDR[MEM_AW+1:2] : AR_ADDR[MEM_AW+1:2];
  assign sel_len   = grant_wr ? AW_LEN : AR_LEN;
  assign sel_burst = grant_wr ? AW_BURST : AR_BURST;
  assign sel_end   = {1'b0, sel_word} + (MEM_AW+1)'(sel_len);
  assign sel_err   = sel_burst[1] ||
                     ((sel_burst == BURST_FIXED) ? ({1'b0, sel_word} >= DepthLim)
                                                 : (sel_end >= DepthLim));

  assign unused_bits = ^{AW_ADDR[ADDR_WIDTH-1:MEM_AW+2], AW_ADDR[1:0],
                         AR_ADDR[ADDR_WIDTH-1:MEM_AW+2], AR_ADDR[1:0]};

  assign WREADY    = (state_q == WR_DATA);
  assign wr_beat   = (state_q == WR_DATA) && WVALID;
  assign mem_we    = wr_beat && !err_q;
  assign mem_en    = mem_we || ((state_q == RD_ADDR) && !err_q);
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? W_DATA : '0;
  assign mem_wstrb = mem_we ? W_STRB : '0;
  assign addr_next = addr_q + MEM_AW'(burst_q == BURST_INCR);

  // SRAM data arrives in the first RD_DATA cycle; it is latched there so a stall holds it.
  assign R_DATA = err_q ? '0 : (rd_first_q ? mem_rdata : rdata_q);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      werr_q     <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
      BVALID     <= 1'b0;
      B_ID       <= '0;
      B_RESP     <= RESP_OKAY;
      RVALID     <= 1'b0;
      R_ID       <= '0;
      R_RESP     <= RESP_OKAY;
      R_LAST     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            addr_q  <= sel_word;
            id_q    <= grant_wr ? AW_ID : AR_ID;
            len_q   <= sel_len;
            burst_q <= sel_burst;
            err_q   <= sel_err;
            werr_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= grant_wr ? WR_DATA : RD_ADDR;
          end
        end
        WR_DATA: begin
          if (WVALID) begin
            if (cnt_q == len_q) begin
              BVALID  <= 1'b1;
              B_ID    <= id_q;
              B_RESP  <= (err_q || werr_q || !W_LAST) ? RESP_SLVERR : RESP_OKAY;
              state_q <= WR_RESP;
            end else begin
              werr_q <= werr_q || W_LAST;
              cnt_q  <= cnt_q + 4'd1;
              addr_q <= addr_next;
            end
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RD_ADDR: begin
          RVALID     <= 1'b1;
          R_ID       <= id_q;
          R_RESP     <= err_q ? RESP_SLVERR : RESP_OKAY;
          R_LAST     <= (cnt_q == len_q);
          rd_first_q <= 1'b1;
          state_q    <= RD_DATA;
        end
        RD_DATA: begin
          rd_first_q <= 1'b0;
          if (rd_first_q) begin
            rdata_q <= mem_rdata;
          end
          if (RREADY) begin
            RVALID <= 1'b0;
            R_LAST <= 1'b0;
            if (cnt_q == len_q) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 4'd1;
              addr_q  <= addr_next;
              state_q <= RD_ADDR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slv_mem_sched.sv
// Bench for axi_slv_mem_sched: synchronous SRAM model plus a word-array reference of memory contents.
module tb_axi_slv_mem_sched;

  localparam int DEPTH = 1024;
  localparam int IW    = 4;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AW_ADDR, AR_ADDR;
  logic [3:0]  AW_ID, AR_ID, AW_LEN, AR_LEN;
  logic [1:0]  AW_BURST, AR_BURST;
  logic        AWVALID, AWREADY, AR_VALID, AR_READY;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        W_LAST, WVALID, WREADY;
  logic [3:0]  B_ID, R_ID;
  logic [1:0]  B_RESP, R_RESP;
  logic        BVALID, BREADY, RVALID, RREADY, R_LAST;
  logic [31:0] R_DATA;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;

  logic [31:0] sram    [DEPTH] = '{default: 32'h0};
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
  int en_cnt = 0;
  int we_cnt = 0;
  int tests  = 0;
  int fails  = 0;
  bit ref_last_wr = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_slv_mem_sched dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AW_ADDR(AW_ADDR), .AW_ID(AW_ID), .AW_LEN(AW_LEN), .AW_BURST(AW_BURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AR_ADDR(AR_ADDR), .AR_ID(AR_ID), .AR_LEN(AR_LEN), .AR_BURST(AR_BURST),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_LAST(W_LAST), .WVALID(WVALID), .WREADY(WREADY),
    .B_ID(B_ID), .B_RESP(B_RESP), .BVALID(BVALID), .BREADY(BREADY),
    .R_ID(R_ID), .R_RESP(R_RESP), .R_DATA(R_DATA), .R_LAST(R_LAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_wstrb[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(posedge ACLK) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_we) we_cnt <= we_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal;
  end

  function automatic bit exp_err(input int addr, input int len, input int burst);
    int w = (addr >> 2) % DEPTH;
    if (burst >= 2) return 1'b1;
    if (burst == 0) return w >= DEPTH;
    return (w + len) >= DEPTH;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic aw_req(input int addr, input int id, input int len, input int burst);
    bit ok = 1'b0;
    AW_ADDR = 32'(addr); AW_ID = IW'(id); AW_LEN = 4'(len); AW_BURST = 2'(burst);
    AWVALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge ACLK);
      if (AWREADY) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok || AR_READY) begin
      fails++;
      $display("FAIL aw_handshake: AWREADY=%0b AR_READY=%0b, required 1/0", AWREADY, AR_READY);
    end
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    ref_last_wr = 1'b1;
  endtask

  task automatic ar_req(input int addr, input int id, input int len, input int burst);
    bit ok = 1'b0;
    AR_ADDR = 32'(addr); AR_ID = IW'(id); AR_LEN = 4'(len); AR_BURST = 2'(burst);
    AR_VALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge ACLK);
      if (AR_READY) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok || AWREADY) begin
      fails++;
      $display("FAIL ar_handshake: AR_READY=%0b AWREADY=%0b, required 1/0", AR_READY, AWREADY);
    end
    @(posedge ACLK); #1;
    AR_VALID = 1'b0;
    ref_last_wr = 1'b0;
  endtask

  // Drives all W beats back-to-back, then the B handshake; W_LAST is raised on beat last_at.
  task automatic write_data(input int addr, input int id, input int len, input int burst,
                            input int last_at, input bit full_strb);
    int          w0  = (addr >> 2) % DEPTH;
    bit          err = exp_err(addr, len, burst);
    logic [1:0]  er  = (err || last_at != len) ? 2'b10 : 2'b00;
    int          we0 = we_cnt;
    int          en0 = en_cnt;
    logic [31:0] d;
    logic [3:0]  s;
    int          w;
    for (int i = 0; i <= len; i++) begin
      d = $urandom;
      s = full_strb ? 4'hF : 4'($urandom_range(1, 15));
      WVALID = 1'b1; W_DATA = d; W_STRB = s; W_LAST = (i == last_at);
      @(negedge ACLK);
      tests++;
      if (WREADY !== 1'b1 || BVALID !== 1'b0) begin
        fails++;
        $display("FAIL w_beat%0d: WREADY=%0b BVALID=%0b, required 1/0", i, WREADY, BVALID);
      end
      w = w0 + ((burst == 1) ? i : 0);
      if (!err) ref_mem[w] = merge(ref_mem[w], d, s);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; W_LAST = 1'b0;
    tests++;
    if (BVALID !== 1'b1) begin
      fails++;
      $display("FAIL b_latency: BVALID=%0b one cycle after last beat, required 1", BVALID);
    end
    tests++;
    if (B_ID !== IW'(id) || B_RESP !== er) begin
      fails++;
      $display("FAIL b_resp: B_ID=%0h B_RESP=%0b, required %0h/%0b", B_ID, B_RESP, id, er);
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge ACLK);
      tests++;
      if (BVALID !== 1'b1 || B_RESP !== er) begin
        fails++;
        $display("FAIL b_hold: BVALID=%0b B_RESP=%0b, required 1/%0b", BVALID, B_RESP, er);
      end
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    tests++;
    if (BVALID !== 1'b0) begin
      fails++;
      $display("FAIL b_clear: BVALID=%0b after handshake, required 0", BVALID);
    end
    tests++;
    if (we_cnt - we0 != (err ? 0 : len + 1) || en_cnt - en0 != (err ? 0 : len + 1)) begin
      fails++;
      $display("FAIL wr_pulses: we=%0d en=%0d, required %0d", we_cnt - we0, en_cnt - en0,
               err ? 0 : len + 1);
    end
    if (!err) begin
      for (int i = 0; i <= ((burst == 1) ? len : 0); i++) begin
        tests++;
        if (sram[w0 + i] !== ref_mem[w0 + i]) begin
          fails++;
          $display("FAIL mem_word%0d: got %08h, required %08h", w0 + i, sram[w0 + i],
                   ref_mem[w0 + i]);
        end
      end
    end
  endtask

  task automatic read_data(input int addr, input int id, input int len, input int burst,
                           input bit stall);
    int          w0  = (addr >> 2) % DEPTH;
    bit          err = exp_err(addr, len, burst);
    int          en0 = en_cnt;
    logic [31:0] exp;
    bit          ok;
    for (int i = 0; i <= len; i++) begin
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
        if (RVALID) begin ok = 1'b1; break; end
        @(negedge ACLK);
      end
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL r_timeout: RVALID=0 on beat %0d, required 1", i);
        return;
      end
      exp = err ? 32'h0 : ref_mem[w0 + ((burst == 1) ? i : 0)];
      tests++;
      if (R_DATA !== exp || R_RESP !== (err ? 2'b10 : 2'b00) || R_ID !== IW'(id) ||
          R_LAST !== (i == len)) begin
        fails++;
        $display("FAIL r_beat%0d: data=%08h resp=%0b id=%0h last=%0b, required %08h/%0b/%0h/%0b",
                 i, R_DATA, R_RESP, R_ID, R_LAST, exp, err ? 2'b10 : 2'b00, id, i == len);
      end
      if (stall) begin
        repeat ($urandom_range(1, 2)) begin
          @(negedge ACLK);
          tests++;
          if (RVALID !== 1'b1 || R_DATA !== exp) begin
            fails++;
            $display("FAIL r_hold%0d: RVALID=%0b data=%08h, required 1/%08h", i, RVALID, R_DATA,
                     exp);
          end
        end
      end
      RREADY = 1'b1;
      @(posedge ACLK); #1;
      RREADY = 1'b0;
    end
    tests++;
    if (RVALID !== 1'b0 || en_cnt - en0 != (err ? 0 : len + 1)) begin
      fails++;
      $display("FAIL rd_end: RVALID=%0b en=%0d, required 0/%0d", RVALID, en_cnt - en0,
               err ? 0 : len + 1);
    end
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    AW_ADDR = '0; AW_ID = '0; AW_LEN = '0; AW_BURST = '0; AWVALID = 1'b0;
    AR_ADDR = '0; AR_ID = '0; AR_LEN = '0; AR_BURST = '0; AR_VALID = 1'b0;
    W_DATA = '0; W_STRB = '0; W_LAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    tests++;
    if ({AWREADY, AR_READY, WREADY, BVALID, RVALID, R_LAST} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready/valid=%06b, required 000000",
               {AWREADY, AR_READY, WREADY, BVALID, RVALID, R_LAST});
    end
    tests++;
    if ({B_RESP, R_RESP, B_ID, R_ID, R_DATA} !== '0) begin
      fails++;
      $display("FAIL reset_resp: B=%0b/%0h R=%0b/%0h/%08h, required all 0", B_RESP, B_ID,
               R_RESP, R_ID, R_DATA);
    end
    tests++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      fails++;
      $display("FAIL reset_mem: en=%0b we=%0b addr=%0h wdata=%08h, required all 0", mem_en,
               mem_we, mem_addr, mem_wdata);
    end
    ARESETn = 1'b1;
    ref_last_wr = 1'b0;
  endtask

  task automatic test_incr_write;
    aw_req(32'h10, 3, 3, 1);
    write_data(32'h10, 3, 3, 1, 3, 1'b1);
  endtask

  task automatic test_read_stall;
    ar_req(32'h10, 9, 3, 1);
    read_data(32'h10, 9, 3, 1, 1'b1);
  endtask

  task automatic test_arbitration;
    for (int it = 0; it < 4; it++) begin
      int wa = $urandom_range(0, 200) * 4;
      int ra = $urandom_range(0, 200) * 4;
      int wl = $urandom_range(0, 3);
      int rl = $urandom_range(0, 3);
      bit exp_wr = !ref_last_wr;
      bit got_wr;
      bit ok = 1'b0;
      AW_ADDR = 32'(wa); AW_ID = IW'(it); AW_LEN = 4'(wl); AW_BURST = 2'b01;
      AR_ADDR = 32'(ra); AR_ID = IW'(it + 8); AR_LEN = 4'(rl); AR_BURST = 2'b01;
      AWVALID = 1'b1; AR_VALID = 1'b1;
      for (int n = 0; n < 50; n++) begin
        @(negedge ACLK);
        if (AWREADY || AR_READY) begin ok = 1'b1; break; end
      end
      tests++;
      if (!ok || (AWREADY && AR_READY)) begin
        fails++;
        $display("FAIL arb_ready%0d: AWREADY=%0b AR_READY=%0b, required exactly one", it,
                 AWREADY, AR_READY);
      end
      got_wr = AWREADY;
      tests++;
      if (got_wr !== exp_wr) begin
        fails++;
        $display("FAIL arb_grant%0d: write_granted=%0b, required %0b", it, got_wr, exp_wr);
      end
      @(posedge ACLK); #1;
      AWVALID = 1'b0; AR_VALID = 1'b0;
      if (got_wr) begin
        ref_last_wr = 1'b1;
        write_data(wa, it, wl, 1, wl, 1'b0);
      end else begin
        ref_last_wr = 1'b0;
        read_data(ra, it + 8, rl, 1, 1'b0);
      end
    end
  endtask

  task automatic test_errors;
    ar_req((DEPTH - 2) * 4, 4, 3, 1);
    read_data((DEPTH - 2) * 4, 4, 3, 1, 1'b0);
    aw_req(32'h100, 5, 2, 2);
    write_data(32'h100, 5, 2, 2, 2, 1'b1);
  endtask

  task automatic test_wlast_fixed;
    aw_req(32'h200, 6, 3, 1);
    write_data(32'h200, 6, 3, 1, 1, 1'b1);
    aw_req(32'h40, 7, 1, 0);
    write_data(32'h40, 7, 1, 0, 1, 1'b0);
    ar_req(32'h40, 2, 1, 0);
    read_data(32'h40, 2, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_read;
    int  en0;
    bit  ok = 1'b0;
    ar_req(32'h10, 1, 3, 1);
    for (int n = 0; n < 50 && !RVALID; n++) @(negedge ACLK);
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (RVALID) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rst_beat2: RVALID=0 before reset, required 1");
    end
    @(negedge ACLK);
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    tests++;
    if (RVALID !== 1'b0 || mem_en !== 1'b0 || BVALID !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort: RVALID=%0b mem_en=%0b BVALID=%0b, required 0/0/0", RVALID,
               mem_en, BVALID);
    end
    ARESETn = 1'b1;
    ref_last_wr = 1'b0;
    en0 = en_cnt;
    repeat (3) @(posedge ACLK);
    #1;
    tests++;
    if (en_cnt != en0 || RVALID !== 1'b0) begin
      fails++;
      $display("FAIL rst_idle: mem_en pulses=%0d RVALID=%0b, required 0/0", en_cnt - en0, RVALID);
    end
    aw_req(32'h80, 12, 1, 1);
    write_data(32'h80, 12, 1, 1, 1, 1'b1);
  endtask

  task automatic test_random;
    for (int t = 0; t < 12; t++) begin
      int addr  = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 20, DEPTH - 1) * 4
                                              : $urandom_range(0, DEPTH - 20) * 4;
      int len   = $urandom_range(0, 15);
      int sel   = $urandom_range(0, 5);
      int burst = (sel < 2) ? 0 : ((sel < 5) ? 1 : 2 + $urandom_range(0, 1));
      int id    = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        aw_req(addr, id, len, burst);
        write_data(addr, id, len, burst, len, 1'b0);
      end else begin
        ar_req(addr, id, len, burst);
        read_data(addr, id, len, burst, $urandom_range(0, 1) == 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr_write();
    test_read_stall();
    test_arbitration();
    test_errors();
    test_wlast_fixed();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
